// File: rtl/entropy_encoder_sequencer.sv
// entropy_encoder_sequencer
// Frame-level controller in front of entropy_encoder. Takes symbol records
// from an upstream valid/ready stream, presents them to the encoder one per
// cycle with no bubbles, raises the encoder's final flag after the last
// symbol, waits for the encoder's last-flag, then holds the encoder in reset
// between frames. Frames abort on upstream underrun or drain timeout.
//
// Ports:
//   top_clk, top_reset          clock, synchronous active-high reset
//   s_valid/s_ready             upstream record handshake
//   s_fl, s_fh, s_symbol,
//   s_nsyms, s_bool, s_last     upstream record fields
//   enc_reset, enc_final_flag   encoder reset and final flag
//   enc_fl .. enc_bool          registered symbol fields to the encoder
//   enc_flag_last               encoder OUT_FLAG_LAST
//   busy, frame_done            frame in progress / normal completion pulse
//   sym_count                   symbols accepted in current or last frame
//   err_underrun, err_timeout   sticky error flags
module entropy_encoder_sequencer #(
  parameter int RANGE_WIDTH   = 16,
  parameter int SYMBOL_WIDTH  = 4,
  parameter int RST_CYCLES    = 4,
  parameter int DRAIN_TIMEOUT = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                    top_clk,
  input  logic                    top_reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [RANGE_WIDTH-1:0]  s_fl,
  input  logic [RANGE_WIDTH-1:0]  s_fh,
  input  logic [SYMBOL_WIDTH-1:0] s_symbol,
  input  logic [SYMBOL_WIDTH:0]   s_nsyms,
  input  logic                    s_bool,
  input  logic                    s_last,
  output logic                    enc_reset,
  output logic                    enc_final_flag,
  output logic [RANGE_WIDTH-1:0]  enc_fl,
  output logic [RANGE_WIDTH-1:0]  enc_fh,
  output logic [SYMBOL_WIDTH-1:0] enc_symbol,
  output logic [SYMBOL_WIDTH:0]   enc_nsyms,
  output logic                    enc_bool,
  input  logic                    enc_flag_last,
  output logic                    busy,
  output logic                    frame_done,
  output logic [CNT_WIDTH-1:0]    sym_count,
  output logic                    err_underrun,
  output logic                    err_timeout
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_RST, ST_IDLE, ST_ENC, ST_LAST, ST_FINAL, ST_DRAIN, ST_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [RCW-1:0] rst_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           accept;
  logic           rst_expired;
  logic           drain_expired;

  // s_ready is registered and is high exactly in IDLE and ENC, so it can
  // qualify the handshake directly.
  assign accept        = s_valid & s_ready;
  assign rst_expired   = (rst_cnt == RCW'(RST_CYCLES - 1));
  assign drain_expired = (drain_cnt == DCW'(DRAIN_TIMEOUT - 1));

  // Next-state decision. In DRAIN the encoder's last-flag wins over an
  // expiring timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:   if (rst_expired) state_nxt = ST_IDLE;
      ST_IDLE:  if (accept) state_nxt = s_last ? ST_LAST : ST_ENC;
      ST_ENC: begin
        if (!s_valid)    state_nxt = ST_RST;
        else if (s_last) state_nxt = ST_LAST;
      end
      ST_LAST:  state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (enc_flag_last)      state_nxt = ST_DONE;
        else if (drain_expired) state_nxt = ST_RST;
      end
      ST_DONE:  state_nxt = ST_RST;
      default:  state_nxt = ST_RST;
    endcase
  end

  // All outputs are registered from the next state, so each output already
  // reflects the state the block is in during the following cycle.
  always_ff @(posedge top_clk) begin
    if (top_reset) begin
      state          <= ST_RST;
      rst_cnt        <= '0;
      drain_cnt      <= '0;
      s_ready        <= 1'b0;
      enc_reset      <= 1'b1;
      enc_final_flag <= 1'b0;
      enc_fl         <= '0;
      enc_fh         <= '0;
      enc_symbol     <= '0;
      enc_nsyms      <= '0;
      enc_bool       <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      sym_count      <= '0;
      err_underrun   <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      state     <= state_nxt;
      rst_cnt   <= (state == ST_RST && state_nxt == ST_RST) ? rst_cnt + RCW'(1) : '0;
      drain_cnt <= (state == ST_DRAIN && state_nxt == ST_DRAIN) ? drain_cnt + DCW'(1) : '0;

      s_ready        <= (state_nxt == ST_IDLE) || (state_nxt == ST_ENC);
      enc_reset      <= (state_nxt == ST_RST) || (state_nxt == ST_IDLE);
      busy           <= !((state_nxt == ST_RST) || (state_nxt == ST_IDLE));
      enc_final_flag <= (state_nxt == ST_FINAL);
      frame_done     <= (state_nxt == ST_DONE);

      if (accept) begin
        enc_fl     <= s_fl;
        enc_fh     <= s_fh;
        enc_symbol <= s_symbol;
        enc_nsyms  <= s_nsyms;
        enc_bool   <= s_bool;
        // First accept of a frame restarts the count; later ones saturate.
        if (state == ST_IDLE)
          sym_count <= CNT_WIDTH'(1);
        else if (!(&sym_count))
          sym_count <= sym_count + CNT_WIDTH'(1);
      end

      if (state == ST_ENC && !s_valid)
        err_underrun <= 1'b1;
      if (state == ST_DRAIN && !enc_flag_last && drain_expired)
        err_timeout <= 1'b1;
    end
  end

endmodule
